// File: rtl/score_ram_writer.sv
// Write side of the score RAM: read-modify-write of one player's slot per record
// request (best score kept or replaced, play count bumped), plus a full-RAM clear sweep.
module score_ram_writer #(
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 16,
    parameter int GUEST_ADDR = 8,
    parameter int NUM_SLOTS  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              clear,
    input  logic              isGuest,
    input  logic [2:0]        intIDin,
    input  logic [3:0]        scoreOnes,
    input  logic [3:0]        scoreTens,
    input  logic [DATA_W-1:0] scoreRAM_Dout,
    output logic              scoreRAM_RW,
    output logic [ADDR_W-1:0] scoreRAM_Addr,
    output logic [DATA_W-1:0] scoreRAM_Din,
    output logic              busy,
    output logic              done,
    output logic              newHigh,
    output logic              error
);

    // state | meaning
    // IDLE  | waiting for start/clear, RAM port parked at addr 0 / data 0
    // RD    | read address of the player's slot presented
    // CMP   | old entry on Dout, new entry computed and registered
    // WR    | new entry written to the slot
    // DONE  | one-cycle completion pulse
    // CLR   | zeroing word cnt_q, one word per cycle
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_CMP  = 3'd2;
    localparam logic [2:0] S_WR   = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;
    localparam logic [2:0] S_CLR  = 3'd5;

    localparam logic [ADDR_W-1:0] LAST_SLOT  = ADDR_W'(NUM_SLOTS - 1);
    localparam logic [ADDR_W-1:0] GUEST_SLOT = ADDR_W'(GUEST_ADDR);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] slot_q, slot_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [3:0]        ones_q, ones_d;
    logic [3:0]        tens_q, tens_d;
    logic [DATA_W-1:0] entry_q, entry_d;
    logic              nh_next_q, nh_next_d;
    logic              newHigh_q, newHigh_d;
    logic              error_q, error_d;

    logic       old_valid;
    logic [6:0] old_count;
    logic [7:0] old_score;
    logic [7:0] new_score;
    logic [6:0] new_count;
    logic       replace;

    assign old_valid = scoreRAM_Dout[15];
    assign old_count = scoreRAM_Dout[14:8];
    assign old_score = scoreRAM_Dout[7:0];
    assign new_score = {tens_q, ones_q};
    // A plain 8-bit compare orders two valid BCD digits correctly.
    assign replace   = !old_valid || (new_score > old_score);

    always_comb begin
        new_count = 7'd1;
        if (old_valid) begin
            new_count = (old_count == 7'd127) ? 7'd127 : old_count + 7'd1;
        end
    end

    always_comb begin
        state_d   = state_q;
        slot_d    = slot_q;
        cnt_d     = cnt_q;
        ones_d    = ones_q;
        tens_d    = tens_q;
        entry_d   = entry_q;
        nh_next_d = nh_next_q;
        newHigh_d = newHigh_q;
        error_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (clear) begin
                    state_d   = S_CLR;
                    cnt_d     = '0;
                    newHigh_d = 1'b0;
                end else if (start) begin
                    if ((scoreOnes > 4'd9) || (scoreTens > 4'd9)) begin
                        error_d = 1'b1;
                    end else begin
                        state_d   = S_RD;
                        slot_d    = isGuest ? GUEST_SLOT : {{(ADDR_W-3){1'b0}}, intIDin};
                        ones_d    = scoreOnes;
                        tens_d    = scoreTens;
                        newHigh_d = 1'b0;
                    end
                end
            end
            S_RD: state_d = S_CMP;
            S_CMP: begin
                entry_d   = {1'b1, new_count, replace ? new_score : old_score};
                nh_next_d = replace;
                state_d   = S_WR;
            end
            S_WR: begin
                newHigh_d = nh_next_q;
                state_d   = S_DONE;
            end
            S_DONE: state_d = S_IDLE;
            S_CLR: begin
                if (cnt_q == LAST_SLOT) begin
                    state_d   = S_DONE;
                    newHigh_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            slot_q    <= '0;
            cnt_q     <= '0;
            ones_q    <= '0;
            tens_q    <= '0;
            entry_q   <= '0;
            nh_next_q <= 1'b0;
            newHigh_q <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            slot_q    <= slot_d;
            cnt_q     <= cnt_d;
            ones_q    <= ones_d;
            tens_q    <= tens_d;
            entry_q   <= entry_d;
            nh_next_q <= nh_next_d;
            newHigh_q <= newHigh_d;
            error_q   <= error_d;
        end
    end

    // Write strobe is gated by rst so an abort never lands one more write.
    always_comb begin
        scoreRAM_RW   = ((state_q == S_WR) || (state_q == S_CLR)) && !rst;
        scoreRAM_Addr = '0;
        scoreRAM_Din  = '0;
        case (state_q)
            S_RD, S_CMP: scoreRAM_Addr = slot_q;
            S_WR: begin
                scoreRAM_Addr = slot_q;
                scoreRAM_Din  = entry_q;
            end
            S_CLR: scoreRAM_Addr = cnt_q;
            default: ;
        endcase
    end

    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_DONE);
    assign newHigh = newHigh_q;
    assign error   = error_q;

endmodule

// File: tb/tb_score_ram_writer.sv
// Directed bench for score_ram_writer with a behavioural 32x16 RAM on its port.
module tb_score_ram_writer;

    logic        clk = 1'b0;
    logic        rst, start, clear, isGuest;
    logic [2:0]  intIDin;
    logic [3:0]  scoreOnes, scoreTens;
    logic [15:0] scoreRAM_Dout;
    logic        scoreRAM_RW;
    logic [4:0]  scoreRAM_Addr;
    logic [15:0] scoreRAM_Din;
    logic        busy, done, newHigh, error;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem [32];
    logic        pre_en = 1'b0;
    logic [4:0]  pre_addr = '0;
    logic [15:0] pre_val = '0;

    always #5 clk = ~clk;

    score_ram_writer dut (
        .clk(clk), .rst(rst), .start(start), .clear(clear), .isGuest(isGuest),
        .intIDin(intIDin), .scoreOnes(scoreOnes), .scoreTens(scoreTens),
        .scoreRAM_Dout(scoreRAM_Dout), .scoreRAM_RW(scoreRAM_RW),
        .scoreRAM_Addr(scoreRAM_Addr), .scoreRAM_Din(scoreRAM_Din),
        .busy(busy), .done(done), .newHigh(newHigh), .error(error)
    );

    // Synchronous RAM: read data appears the cycle after the address.
    always @(posedge clk) begin
        if (pre_en) mem[pre_addr] <= pre_val;
        else if (scoreRAM_RW) mem[scoreRAM_Addr] <= scoreRAM_Din;
        scoreRAM_Dout <= mem[scoreRAM_Addr];
    end

    initial begin
        #300000;
        $display("FAIL timeout: simulation did not finish, got running, need finished");
        $fatal(1, "timeout");
    end

    task automatic preload(input logic [4:0] a, input logic [15:0] v);
        pre_en = 1'b1; pre_addr = a; pre_val = v;
        @(negedge clk);
        pre_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; clear = 1'b0; isGuest = 1'b0;
        intIDin = '0; scoreOnes = '0; scoreTens = '0;
        repeat (3) @(negedge clk);
        checks++; if (scoreRAM_RW !== 1'b0) begin errors++; $display("FAIL reset_rw got %b need 0", scoreRAM_RW); end
        checks++; if ({busy, done, newHigh, error} !== 4'b0) begin errors++; $display("FAIL reset_flags got %b need 0000", {busy, done, newHigh, error}); end
        checks++; if ({scoreRAM_Addr, scoreRAM_Din} !== 21'h0) begin errors++; $display("FAIL reset_port got %h/%h need 0/0", scoreRAM_Addr, scoreRAM_Din); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Clear sweep; optionally with start raised alongside clear and held during the sweep.
    task automatic test_clear(input logic with_start, input string tag);
        clear = 1'b1; start = with_start;
        intIDin = 3'd3; scoreTens = 4'd1; scoreOnes = 4'd1; isGuest = 1'b0;
        @(negedge clk);
        clear = 1'b0;
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (scoreRAM_RW !== 1'b1 || scoreRAM_Addr !== 5'(i) || scoreRAM_Din !== 16'h0 || busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL %s_sweep cycle %0d got rw=%b addr=%0d din=%h busy=%b done=%b need rw=1 addr=%0d din=0000 busy=1 done=0",
                         tag, i, scoreRAM_RW, scoreRAM_Addr, scoreRAM_Din, busy, done, i);
            end
            @(negedge clk);
        end
        start = 1'b0;
        checks++; if (done !== 1'b1 || scoreRAM_RW !== 1'b0 || newHigh !== 1'b0) begin errors++; $display("FAIL %s_done got done=%b rw=%b nh=%b need 1 0 0", tag, done, scoreRAM_RW, newHigh); end
        @(negedge clk);
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL %s_after got done=%b busy=%b need 0 0", tag, done, busy); end
        for (int i = 0; i < 32; i++) begin
            checks++; if (mem[i] !== 16'h0) begin errors++; $display("FAIL %s_mem[%0d] got %h need 0000", tag, i, mem[i]); end
        end
        @(negedge clk);
        checks++; if (busy !== 1'b0 || scoreRAM_RW !== 1'b0) begin errors++; $display("FAIL %s_idle got busy=%b rw=%b need 0 0", tag, busy, scoreRAM_RW); end
    endtask

    task automatic test_record(input string tag, input logic g, input logic [2:0] id,
                               input logic [3:0] t, input logic [3:0] o,
                               input logic [4:0] ea, input logic [15:0] ed, input logic enh);
        isGuest = g; intIDin = id; scoreTens = t; scoreOnes = o; start = 1'b1;
        @(negedge clk);
        // Inputs scrambled after acceptance must not matter.
        start = 1'b0; isGuest = ~g; intIDin = ~id; scoreTens = 4'd0; scoreOnes = 4'd1;
        checks++; if (scoreRAM_RW !== 1'b0 || scoreRAM_Addr !== ea || busy !== 1'b1) begin errors++; $display("FAIL %s_rd got rw=%b addr=%0d busy=%b need 0 %0d 1", tag, scoreRAM_RW, scoreRAM_Addr, busy, ea); end
        @(negedge clk);
        checks++; if (scoreRAM_RW !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL %s_cmp got rw=%b done=%b need 0 0", tag, scoreRAM_RW, done); end
        @(negedge clk);
        checks++; if (scoreRAM_RW !== 1'b1 || scoreRAM_Addr !== ea || scoreRAM_Din !== ed) begin errors++; $display("FAIL %s_wr got rw=%b addr=%0d din=%h need 1 %0d %h", tag, scoreRAM_RW, scoreRAM_Addr, scoreRAM_Din, ea, ed); end
        @(negedge clk);
        checks++; if (done !== 1'b1 || newHigh !== enh || scoreRAM_RW !== 1'b0) begin errors++; $display("FAIL %s_done got done=%b nh=%b rw=%b need 1 %b 0", tag, done, newHigh, scoreRAM_RW, enh); end
        @(negedge clk);
        checks++; if (done !== 1'b0 || busy !== 1'b0 || newHigh !== enh) begin errors++; $display("FAIL %s_idle got done=%b busy=%b nh=%b need 0 0 %b", tag, done, busy, newHigh, enh); end
        checks++; if (mem[ea] !== ed) begin errors++; $display("FAIL %s_mem got %h need %h", tag, mem[ea], ed); end
    endtask

    task automatic test_bad_bcd(input string tag, input logic [3:0] t, input logic [3:0] o);
        isGuest = 1'b0; intIDin = 3'd1; scoreTens = t; scoreOnes = o; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++; if (error !== 1'b1 || busy !== 1'b0 || scoreRAM_RW !== 1'b0 || scoreRAM_Addr !== 5'd0) begin errors++; $display("FAIL %s_err got err=%b busy=%b rw=%b addr=%0d need 1 0 0 0", tag, error, busy, scoreRAM_RW, scoreRAM_Addr); end
        @(negedge clk);
        checks++; if (error !== 1'b0 || busy !== 1'b0 || newHigh !== 1'b1) begin errors++; $display("FAIL %s_after got err=%b busy=%b nh=%b need 0 0 1", tag, error, busy, newHigh); end
    endtask

    task automatic test_reset_mid_clear();
        for (int i = 0; i < 32; i++) preload(5'(i), 16'h5A5A);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin isGuest = 1'b0; intIDin = 3'd2; scoreTens = 4'd5; scoreOnes = 4'd5; start = 1'b1; end
            if (i == 5) start = 1'b0;
            @(negedge clk);
        end
        checks++; if (scoreRAM_Addr !== 5'd10 || busy !== 1'b1) begin errors++; $display("FAIL abort_pos got addr=%0d busy=%b need 10 1", scoreRAM_Addr, busy); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (scoreRAM_RW !== 1'b0 || {busy, done, newHigh, error} !== 4'b0 || scoreRAM_Addr !== 5'd0 || scoreRAM_Din !== 16'h0) begin
            errors++; $display("FAIL abort_outputs got rw=%b flags=%b addr=%0d din=%h need 0 0000 0 0000", scoreRAM_RW, {busy, done, newHigh, error}, scoreRAM_Addr, scoreRAM_Din);
        end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (busy !== 1'b0 || scoreRAM_RW !== 1'b0) begin errors++; $display("FAIL abort_idle cycle %0d got busy=%b rw=%b need 0 0", i, busy, scoreRAM_RW); end
        end
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (mem[i] !== ((i < 10) ? 16'h0000 : 16'h5A5A)) begin
                errors++; $display("FAIL abort_mem[%0d] got %h need %h", i, mem[i], (i < 10) ? 16'h0000 : 16'h5A5A);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 16'hABCD;
        @(negedge clk);
        test_reset();
        test_clear(1'b0, "clear");
        test_record("rec42", 1'b0, 3'd3, 4'd4, 4'd2, 5'd3, 16'h8142, 1'b1);
        test_record("rec37", 1'b0, 3'd3, 4'd3, 4'd7, 5'd3, 16'h8242, 1'b0);
        test_record("rec42eq", 1'b0, 3'd3, 4'd4, 4'd2, 5'd3, 16'h8342, 1'b0);
        preload(5'd8, 16'hFF10);
        test_record("guest99", 1'b1, 3'd5, 4'd9, 4'd9, 5'd8, 16'hFF99, 1'b1);
        checks++; if (mem[5] !== 16'h0000) begin errors++; $display("FAIL guest_slot5 got %h need 0000", mem[5]); end
        test_bad_bcd("bad_ones", 4'd1, 4'hA);
        test_bad_bcd("bad_tens", 4'hC, 4'd3);
        test_clear(1'b1, "clear_start");
        test_reset_mid_clear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/score_ram_writer.md
Name: score_ram_writer

Overview:
- Write side of the score RAM: records a player's finished-game score into the 32x16 score RAM that the Scoring block reads for its top-score display.
- Per request: one read-modify-write of the player's slot. The stored best score is kept or replaced, and the play count is incremented.
- Also provides a full-RAM clear sweep.
- Sits between the game control FSM and the score RAM port. The port is muxed with Scoring's read port under control-FSM arbitration, which is outside this block.

Parameters:
- ADDR_W, 5, score RAM address width.
- DATA_W, 16, score RAM word width (entry format below is fixed for 16).
- GUEST_ADDR, 8, slot used when isGuest=1.
- NUM_SLOTS, 32, number of words zeroed by a clear sweep.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  record request, sampled only in IDLE.
- clear  in  1  clear-all request, sampled only in IDLE.
- isGuest  in  1  1 = use GUEST_ADDR and ignore intIDin.
- intIDin  in  3  internal player ID 0..7; slot address = {2'b00,intIDin}.
- scoreOnes  in  4  BCD ones digit of the new score.
- scoreTens  in  4  BCD tens digit of the new score.
- scoreRAM_Dout  in  16  RAM read data, valid the cycle after the read address is presented.
- scoreRAM_RW  out  1  0 = read, 1 = write (write on clk edge).
- scoreRAM_Addr  out  5  RAM address.
- scoreRAM_Din  out  16  RAM write data.
- busy  out  1  high in any non-IDLE state.
- done  out  1  one-cycle pulse when a record or clear completes.
- newHigh  out  1  held from DONE until the next accepted request: last record replaced the stored best.
- error  out  1  one-cycle pulse: request rejected because of invalid BCD.

Behaviour:
- Entry format: [15] valid, [14:8] play count (7-bit), [7:4] best tens BCD, [3:0] best ones BCD.
- Reset values: all outputs 0, scoreRAM_RW=0, state IDLE. A reset mid-operation aborts immediately; no further write is issued and the partial clear is not resumed.
- Input capture: on acceptance, latch slot address, scoreOnes and scoreTens. Later input changes have no effect.
- States and transitions:
  - IDLE: clear=1 -> CLR with counter=0 (clear wins over a simultaneous start). Else start=1 -> check BCD. Either digit >9 -> error pulse next cycle, stay IDLE, no RAM access. Else -> RD.
  - RD (1 cycle): Addr=slot, RW=0.
  - CMP (1 cycle): Dout holds the old entry. Compute the new entry:
    - count = old valid ? min(old count+1, 127) : 1 (saturates at 127, never wraps).
    - Replace the score if old valid=0 or {tens,ones} > {old tens, old ones}, compared as a two-digit BCD value. Equal scores are not replaced.
    - Register newHigh_next.
  - WR (1 cycle): RW=1, Addr=slot, Din={1'b1,count,score}.
  - DONE (1 cycle): done=1, newHigh updated, RW=0 -> IDLE.
  - CLR: RW=1, Addr=counter, Din=0 for NUM_SLOTS consecutive cycles (addresses 0..NUM_SLOTS-1, counter must not wrap past the last). Then DONE with newHigh=0.
- Latency:
  - Record: start sampled at edge T0; RD during T0-T1, CMP T1-T2, WR T2-T3, done high T3-T4. Accepts a new request at T4.
  - Clear: done high NUM_SLOTS+1 cycles after acceptance.
- Port timing:
  - scoreRAM_RW is 1 only in WR and CLR.
  - In IDLE, Addr and Din hold 0.
  - start or clear while busy: ignored, not queued.
- No RAM access occurs other than those listed.

Test Plan:
1. Reset, then clear -> 32 writes, addresses 0..31 with Din=0x0000, done pulses exactly 33 cycles after acceptance, busy low after.
2. After clear, start with intIDin=3, tens=4, ones=2 -> read addr 3, write addr 3 Din=0x8142, newHigh=1, done 4 cycles after start.
3. Same ID with score 37 -> Din=0x8242 (count 2, best kept), newHigh=0. Then score 42 -> Din=0x8342, newHigh=0 (equal score not replaced).
4. isGuest=1, intIDin=5, score 99 over an entry preloaded 0xFF10 -> addr 8, Din=0xFF99 (count saturated at 127), newHigh=1.
5. start with ones=0xA -> error pulse, no RAM access, busy stays 0. Then start and clear asserted together -> clear sweep runs, the record is not performed.
6. rst asserted during CLR at counter=10 -> next cycle RW=0, all outputs 0, IDLE; RAM words 10..31 untouched. A start asserted while busy is never acted on.
